// File: rtl/nibble_pkg.sv
// Shared types and constants for the serial-to-nibble deserializer.
package nibble_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [1:0] bidx_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int    WORD_BITS = 4;
  localparam bidx_t LAST_IDX  = bidx_t'(WORD_BITS - 1);

  // Output bit position for serial bit number idx.
  function automatic bidx_t bit_pos(input bidx_t idx, input logic lsb_first);
    bidx_t pos;
    if (lsb_first) begin
      pos = idx;
    end else begin
      pos = LAST_IDX - idx;
    end
    return pos;
  endfunction

  // Complete a word from the three stored bits plus the final serial bit.
  function automatic nibble_t merge_word(input nibble_t part, input logic b, input logic lsb_first);
    nibble_t w;
    if (lsb_first) begin
      w = {b, part[2:0]};
    end else begin
      w = {part[3:1], b};
    end
    return w;
  endfunction

endpackage

// File: rtl/nibble_shreg.sv
// Bit index and partial-word storage for the first three bits of each nibble.
module nibble_shreg
  import nibble_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic    clk,
  input  logic    nrst,
  input  logic    flush,
  input  logic    shift_en,
  input  logic    din,
  output nibble_t part_word,
  output bidx_t   bit_idx
);

  nibble_t r_part;
  bidx_t   r_idx;

  // Store accepted bits 0..2; the final bit clears storage since the top merges it.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_part <= 4'b0000;
      r_idx  <= 2'd0;
    end else if (flush) begin
      r_part <= 4'b0000;
      r_idx  <= 2'd0;
    end else if (shift_en) begin
      if (r_idx == LAST_IDX) begin
        r_part <= 4'b0000;
        r_idx  <= 2'd0;
      end else begin
        r_part[bit_pos(r_idx, LSB_FIRST)] <= din;
        r_idx                             <= r_idx + 2'd1;
      end
    end
  end

  assign part_word = r_part;
  assign bit_idx   = r_idx;

endmodule

// File: rtl/nibble_deser.sv
// Serial-to-nibble deserializer with valid/ready output stage and delivery counter.
module nibble_deser
  import nibble_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       flush,
  input  logic       din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [3:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] word_cnt
);

  nibble_t    w_part;
  bidx_t      w_idx;
  logic       w_last;
  logic       w_accept;
  logic       w_load;
  logic       w_hs;
  state_t     r_state;
  state_t     w_next_state;
  nibble_t    r_data;
  logic [7:0] r_cnt;

  nibble_shreg #(
    .LSB_FIRST (LSB_FIRST)
  ) u_shreg (
    .clk       (clk),
    .nrst      (nrst),
    .flush     (flush),
    .shift_en  (w_accept),
    .din       (din),
    .part_word (w_part),
    .bit_idx   (w_idx)
  );

  // Only the word-completing bit can stall, and only when the held word is not leaving.
  assign w_last    = (w_idx == LAST_IDX);
  assign din_ready = !(w_last && out_valid && !out_ready);
  assign w_accept  = din_valid && din_ready;
  assign w_load    = w_accept && w_last && !flush;
  assign w_hs      = out_valid && out_ready;

  // Output FSM state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Output FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      EMPTY: begin
        if (w_load) begin
          w_next_state = FULL;
        end else begin
          w_next_state = EMPTY;
        end
      end
      FULL: begin
        if (w_load) begin
          w_next_state = FULL;
        end else if (w_hs) begin
          w_next_state = EMPTY;
        end else begin
          w_next_state = FULL;
        end
      end
      default: w_next_state = EMPTY;
    endcase
  end

  // Output FSM decode.
  always_comb begin
    out_valid = 1'b0;
    case (r_state)
      EMPTY:   out_valid = 1'b0;
      FULL:    out_valid = 1'b1;
      default: out_valid = 1'b0;
    endcase
  end

  // Output word register; only a completed word changes it.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_data <= 4'b0000;
    end else if (w_load) begin
      r_data <= merge_word(w_part, din, LSB_FIRST);
    end
  end

  // Delivered-word counter, wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= 8'd0;
    end else if (w_hs) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign out_data = r_data;
  assign word_cnt = r_cnt;

endmodule

// File: tb/tb_nibble_deser.sv
// Scoreboard bench for nibble_deser: one instance per bit ordering, shared stimulus.
module tb_nibble_deser;

  logic       clk = 1'b0;
  logic       nrst;
  logic       flush;
  logic       din;
  logic       din_valid;
  logic       out_ready;
  logic       rdy1, rdy0, val1, val0;
  logic [3:0] dat1, dat0;
  logic [7:0] cnt1, cnt0;

  int n_total = 0;
  int n_pass  = 0;

  logic [3:0] q1[$];
  logic [3:0] q0[$];

  always #5 clk = ~clk;

  nibble_deser #(.LSB_FIRST(1'b1)) u_dut_lsb (
    .clk       (clk),
    .nrst      (nrst),
    .flush     (flush),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (rdy1),
    .out_data  (dat1),
    .out_valid (val1),
    .out_ready (out_ready),
    .word_cnt  (cnt1)
  );

  nibble_deser #(.LSB_FIRST(1'b0)) u_dut_msb (
    .clk       (clk),
    .nrst      (nrst),
    .flush     (flush),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (rdy0),
    .out_data  (dat0),
    .out_valid (val0),
    .out_ready (out_ready),
    .word_cnt  (cnt0)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every delivered word must match the head of its scoreboard queue.
  always @(negedge clk) begin
    if (nrst === 1'b1 && out_ready === 1'b1) begin
      if (val1 === 1'b1) begin
        if (q1.size() == 0) begin
          n_total++;
          $display("FAIL lsb_extra_word: got %0h, expected no word", dat1);
        end else begin
          check("lsb_word", {4'd0, dat1}, {4'd0, q1.pop_front()});
        end
      end
      if (val0 === 1'b1) begin
        if (q0.size() == 0) begin
          n_total++;
          $display("FAIL msb_extra_word: got %0h, expected no word", dat0);
        end else begin
          check("msb_word", {4'd0, dat0}, {4'd0, q0.pop_front()});
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    bit done;
    done      = 1'b0;
    din       = b;
    din_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (rdy1 === 1'b1) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_total++;
      $display("FAIL send_timeout: din_ready stayed 0, expected 1");
    end
  endtask

  task automatic send_word(input logic [3:0] bits);
    for (int i = 0; i < 4; i++) send_bit(bits[i]);
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    nrst      = 1'b0;
    flush     = 1'b0;
    din_valid = 1'b0;
    q1.delete();
    q0.delete();
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  initial begin
    logic [3:0] nib;
    logic [3:0] rev;
    nrst      = 1'b0;
    flush     = 1'b0;
    din       = 1'b0;
    din_valid = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #2;
    check("rst_din_ready", {7'd0, rdy1}, 8'd1);
    check("rst_out_valid", {7'd0, val1}, 8'd0);
    check("rst_out_data", {4'd0, dat1}, 8'd0);
    check("rst_out_data_msb", {4'd0, dat0}, 8'd0);
    check("rst_word_cnt", cnt1, 8'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;

    // Bits 1,0,1,1: 1101 LSB-first, 1011 MSB-first
    q1.push_back(4'b1101);
    q0.push_back(4'b1011);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("t1_no_early_valid", {7'd0, val1}, 8'd0);
    send_bit(1'b1);
    din_valid = 1'b0;
    check("t1_valid_latency", {7'd0, val1}, 8'd1);
    check("t1_valid_latency_msb", {7'd0, val0}, 8'd1);
    @(posedge clk);
    #1;
    check("t1_word_cnt", cnt1, 8'd1);
    check("t1_valid_clears", {7'd0, val1}, 8'd0);

    // Backpressure: 8 bits with out_ready low, stall on the 8th
    do_reset();
    out_ready = 1'b0;
    q1.push_back(4'b1100);
    q1.push_back(4'b0111);
    q0.push_back(4'b0011);
    q0.push_back(4'b1110);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    din       = 1'b0;
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_stall_ready", {7'd0, rdy1}, 8'd0);
      check("t2_hold_valid", {7'd0, val1}, 8'd1);
      check("t2_hold_data", {4'd0, dat1}, 8'h0c);
      check("t2_hold_data_msb", {4'd0, dat0}, 8'h03);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    check("t2_back_to_back_valid", {7'd0, val1}, 8'd1);
    @(posedge clk);
    #1;
    check("t2_word_cnt", cnt1, 8'd2);
    check("t2_valid_clears", {7'd0, val1}, 8'd0);
    check("t2_q_empty", 8'(q1.size() + q0.size()), 8'd0);

    // Flush discards two bits plus the bit offered in the flush cycle
    do_reset();
    out_ready = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    flush     = 1'b1;
    din       = 1'b1;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    q1.push_back(4'b0110);
    q0.push_back(4'b0110);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    idle(2);
    check("t3_word_cnt", cnt1, 8'd1);
    check("t3_q_empty", 8'(q1.size() + q0.size()), 8'd0);

    // Held word, flush leaves it alone, then reset mid-word
    do_reset();
    out_ready = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    din_valid = 1'b0;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("t4_flush_keeps_valid", {7'd0, val1}, 8'd1);
    check("t4_flush_keeps_data", {4'd0, dat1}, 8'h09);
    check("t4_flush_keeps_cnt", cnt1, 8'd0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    din_valid = 1'b0;
    nrst      = 1'b0;
    q1.delete();
    q0.delete();
    #2;
    check("t4_rst_valid", {7'd0, val1}, 8'd0);
    check("t4_rst_valid_msb", {7'd0, val0}, 8'd0);
    check("t4_rst_data", {4'd0, dat1}, 8'd0);
    check("t4_rst_cnt", cnt1, 8'd0);
    check("t4_rst_din_ready", {7'd0, rdy1}, 8'd1);
    #2;
    nrst = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    q1.push_back(4'b0010);
    q0.push_back(4'b0100);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    idle(2);
    check("t4_fresh_cnt", cnt1, 8'd1);
    check("t4_q_empty", 8'(q1.size() + q0.size()), 8'd0);

    // 256 back-to-back words wrap the counter
    do_reset();
    out_ready = 1'b1;
    for (int w = 0; w < 255; w++) begin
      nib = 4'(w);
      rev = {nib[0], nib[1], nib[2], nib[3]};
      q1.push_back(nib);
      q0.push_back(rev);
      send_word(nib);
    end
    idle(2);
    check("t5_cnt_255", cnt1, 8'd255);
    check("t5_cnt_255_msb", cnt0, 8'd255);
    q1.push_back(4'b1111);
    q0.push_back(4'b1111);
    send_word(4'b1111);
    idle(2);
    check("t5_cnt_wrap", cnt1, 8'd0);
    check("t5_cnt_wrap_msb", cnt0, 8'd0);
    check("t5_q_empty", 8'(q1.size() + q0.size()), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nibble_deser.md
NIBBLE_DESER -- requirements
Module: nibble_deser

Interface
REQ-001 The block SHALL have parameter LSB_FIRST, default 1, meaning the first accepted serial bit lands in out_data[0] (0: the first bit lands in out_data[3]).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port nrst, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port flush, input, 1 bit, synchronous discard of any partially assembled word.
REQ-005 The block SHALL have port din, input, 1 bit, serial data bit.
REQ-006 The block SHALL have port din_valid, input, 1 bit, din is valid this cycle.
REQ-007 The block SHALL have port din_ready, output, 1 bit, the block accepts din this cycle.
REQ-008 The block SHALL have port out_data, output, 4 bits, assembled word feeding the downstream 4-bit detector input.
REQ-009 The block SHALL have port out_valid, output, 1 bit, out_data holds an undelivered word.
REQ-010 The block SHALL have port out_ready, input, 1 bit, downstream accepts out_data this cycle.
REQ-011 The block SHALL have port word_cnt, output, 8 bits, count of words delivered (out_valid && out_ready).

Function
REQ-012 A bit SHALL be accepted exactly on cycles where din_valid && din_ready.
REQ-013 A 2-bit bit index (0..3) SHALL advance by 1 per accepted bit and wrap 3->0 on the 4th accepted bit.
REQ-014 Accepted bits 0..2 SHALL be stored in a shift register at the position set by LSB_FIRST.
REQ-015 The 4th accepted bit SHALL be merged with the stored bits and load out_data with out_valid=1 on the same edge (latency 1 cycle from the 4th bit to out_valid).
REQ-016 din_ready SHALL be 0 only when bit index==3 && out_valid && !out_ready; otherwise din_ready SHALL be 1 (combinational, no bubble).
REQ-017 On a handshake with no new word, out_valid SHALL clear next cycle.
REQ-018 A simultaneous handshake and 4th-bit accept SHALL load the new word with out_valid staying 1 (back-to-back words, zero dead cycles).
REQ-019 While out_valid && !out_ready, out_data SHALL hold stable.
REQ-020 Bits 0..2 of the next word SHALL continue to be accepted while the output word is held.
REQ-021 flush SHALL clear the bit index and shift register next edge; an accepted bit in the flush cycle SHALL be discarded.
REQ-022 flush SHALL NOT affect out_valid, out_data or word_cnt.
REQ-023 word_cnt SHALL increment by 1 per handshake, wrapping 255->0.
REQ-024 The two-state output FSM SHALL have states EMPTY and FULL: EMPTY->FULL on word load; FULL->EMPTY on handshake without load; FULL->FULL otherwise.

Reset
REQ-025 On nrst=0, the block SHALL asynchronously set bit index=0, shift register=0, out_data=4'b0000, out_valid=0, word_cnt=0, FSM=EMPTY.
REQ-026 During reset, din_ready SHALL read 1 (derived combinationally from reset state).
REQ-027 Reset asserted mid-word SHALL discard the partial word and any held output word without delivery.

Structure
REQ-028 Package nibble_pkg SHALL hold typedef nibble_t (logic [3:0]), typedef bidx_t (logic [1:0]), the FSM state enum (EMPTY, FULL), and constant WORD_BITS=4.
REQ-029 The shift register and bit index SHALL be the sub-module nibble_shreg (ports clk, nrst, flush, shift_en, din, LSB_FIRST; outputs partial word and bit index), instantiated once.
REQ-030 The output register, FSM, handshake and word_cnt SHALL reside in nibble_deser.

Verification
REQ-031 Reset then bits 1,0,1,1 with LSB_FIRST=1 and out_ready=1 SHALL yield out_data=4'b1101 with out_valid high one cycle after the 4th bit, and word_cnt=1.
REQ-032 The same bits with LSB_FIRST=0 SHALL yield out_data=4'b1011.
REQ-033 out_ready=0 with 8 bits offered continuously SHALL stall din_ready=0 on the 8th bit, keeping the first word stable; raising out_ready SHALL deliver both words in consecutive cycles, word_cnt=2.
REQ-034 Two bits then flush, then bits 0,1,1,0 (LSB_FIRST=1) SHALL yield only out_data=4'b0110.
REQ-035 nrst pulsed low after 3 bits with one word held SHALL bring out_valid=0, word_cnt=0, and the next 4 bits SHALL form a fresh word.
REQ-036 256 delivered words SHALL wrap word_cnt to 0.
